// File: rtl/rgb_feeder_pkg.sv
// Shared types and constants for the RGB window feeder.
// Column packing: the lowest DATA_WIDTH slice is the oldest row (y-2), the top slice is row y.
package rgb_feeder_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StFill,
    StStream,
    StDone
  } feeder_state_e;

  // Default geometry and the counter widths derived from it.
  localparam int unsigned ImgWidthDef  = 32;
  localparam int unsigned ImgHeightDef = 32;
  localparam int unsigned XCntWidthDef = $clog2(ImgWidthDef);
  localparam int unsigned YCntWidthDef = $clog2(ImgHeightDef);

  // Slice index of each row inside a packed column.
  localparam int unsigned ColRowY2Idx = 0;
  localparam int unsigned ColRowY1Idx = 1;
  localparam int unsigned ColRowYIdx  = 2;
  localparam int unsigned ColRows     = 3;
  localparam int unsigned KernelTaps  = 9;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rgb_window_feeder_if.sv
// Raster-order RGB pixel stream: valid/ready handshake plus three pixel components.
interface rgb_window_feeder_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_pixel_r;
  logic [DATA_WIDTH-1:0] s_pixel_g;
  logic [DATA_WIDTH-1:0] s_pixel_b;

  modport master (
    output s_valid,
    output s_pixel_r,
    output s_pixel_g,
    output s_pixel_b,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_pixel_r,
    input  s_pixel_g,
    input  s_pixel_b,
    output s_ready
  );

endinterface

// File: rtl/rgb_line_buffer.sv
// Two IMG_WIDTH-deep line delays for one colour channel, sharing address x.
// Reads are combinational and see the contents before this cycle's write, so the
// row-1 value can be shifted down into row 0 at the same time the new pixel lands.
// The RAM has no reset; stale contents are masked or overwritten by the control logic.
module rgb_line_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_pixel,
  output logic [DATA_WIDTH-1:0] o_lb0,
  output logic [DATA_WIDTH-1:0] o_lb1
);

  logic [DATA_WIDTH-1:0] r_lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_lb1 [IMG_WIDTH];

  assign o_lb0 = r_lb0[i_addr];
  assign o_lb1 = r_lb1[i_addr];

  // Shift the column up one line: lb1 -> lb0, new pixel -> lb1.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_lb0[i_addr] <= r_lb1[i_addr];
      r_lb1[i_addr] <= i_pixel;
    end
  end

endmodule

// File: rtl/rgb_window_feeder.sv
// Source side of the RGB 3x3 systolic convolution path: latches kernels on start,
// buffers two lines per channel and presents one 3-row column per accepted pixel.
// Build option: define RGB_FEEDER_ZERO_PAD_EN to skip FILL and emit a column for every
// pixel, with rows above the image top read as zero.
module rgb_window_feeder
  import rgb_feeder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = ImgWidthDef,
  parameter int unsigned IMG_HEIGHT = ImgHeightDef
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [KernelTaps*DATA_WIDTH-1:0] weights_r_in,
  input  logic [KernelTaps*DATA_WIDTH-1:0] weights_g_in,
  input  logic [KernelTaps*DATA_WIDTH-1:0] weights_b_in,
  rgb_window_feeder_if.slave              s_if,
  output logic [KernelTaps*DATA_WIDTH-1:0] weights_r,
  output logic [KernelTaps*DATA_WIDTH-1:0] weights_g,
  output logic [KernelTaps*DATA_WIDTH-1:0] weights_b,
  output logic                            load_weight,
  output logic [ColRows*DATA_WIDTH-1:0]    input_col_r,
  output logic [ColRows*DATA_WIDTH-1:0]    input_col_g,
  output logic [ColRows*DATA_WIDTH-1:0]    input_col_b,
  output logic                            col_valid,
  output logic                            col_last,
  output logic                            start_conv,
  output logic                            total_window_done,
  output logic                            busy
);

  localparam int unsigned XW = cnt_width(IMG_WIDTH);
  localparam int unsigned YW = cnt_width(IMG_HEIGHT);
  localparam int unsigned CW = ColRows * DATA_WIDTH;
  localparam int unsigned KW = KernelTaps * DATA_WIDTH;

  localparam logic [XW-1:0] XLast     = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] YLast     = YW'(IMG_HEIGHT - 1);
  localparam logic [YW-1:0] YFillLast = YW'(1);

  feeder_state_e r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_s_ready;
  logic          r_load_weight;
  logic          r_col_valid;
  logic          r_col_last;
  logic          r_start_conv;
  logic          r_done;
  logic          r_busy;
  logic [KW-1:0] r_w_r;
  logic [KW-1:0] r_w_g;
  logic [KW-1:0] r_w_b;
  logic [CW-1:0] r_col [ColRows];

  logic                  w_accept;
  logic                  w_x_last;
  logic                  w_y_last;
  logic [DATA_WIDTH-1:0] w_pix [ColRows];
  logic [DATA_WIDTH-1:0] w_lb0 [ColRows];
  logic [DATA_WIDTH-1:0] w_lb1 [ColRows];
  logic [CW-1:0]         w_col [ColRows];

  assign w_accept = s_if.s_valid & r_s_ready;
  assign w_x_last = (r_x == XLast);
  assign w_y_last = (r_y == YLast);

  assign w_pix[0] = s_if.s_pixel_r;
  assign w_pix[1] = s_if.s_pixel_g;
  assign w_pix[2] = s_if.s_pixel_b;

  for (genvar c = 0; c < ColRows; c++) begin : g_lb
    rgb_line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .IMG_WIDTH  (IMG_WIDTH),
      .ADDR_WIDTH (XW)
    ) u_lb (
      .clk     (clk),
      .i_we    (w_accept),
      .i_addr  (r_x),
      .i_pixel (w_pix[c]),
      .o_lb0   (w_lb0[c]),
      .o_lb1   (w_lb1[c])
    );
  end

  // Assemble the column for the pixel currently offered; padding masks by row, not RAM.
  always_comb begin
    for (int c = 0; c < ColRows; c++) begin
      w_col[c] = '0;
      w_col[c][ColRowYIdx*DATA_WIDTH +: DATA_WIDTH]  = w_pix[c];
      w_col[c][ColRowY1Idx*DATA_WIDTH +: DATA_WIDTH] = w_lb1[c];
      w_col[c][ColRowY2Idx*DATA_WIDTH +: DATA_WIDTH] = w_lb0[c];
`ifdef RGB_FEEDER_ZERO_PAD_EN
      if (r_y == '0) begin
        w_col[c][ColRowY1Idx*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
      if (r_y < YW'(2)) begin
        w_col[c][ColRowY2Idx*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
`endif
    end
  end

  // Control FSM with raster counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_x           <= '0;
      r_y           <= '0;
      r_s_ready     <= 1'b0;
      r_load_weight <= 1'b0;
      r_col_valid   <= 1'b0;
      r_col_last    <= 1'b0;
      r_start_conv  <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_w_r         <= '0;
      r_w_g         <= '0;
      r_w_b         <= '0;
      for (int c = 0; c < ColRows; c++) begin
        r_col[c] <= '0;
      end
    end else begin
      r_load_weight <= 1'b0;
      r_col_valid   <= 1'b0;
      r_col_last    <= 1'b0;
      r_done        <= 1'b0;

      if (w_accept) begin
        if (w_x_last) begin
          r_x <= '0;
          r_y <= w_y_last ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end

      case (r_state)
        StIdle: begin
          if (start) begin
            r_w_r         <= weights_r_in;
            r_w_g         <= weights_g_in;
            r_w_b         <= weights_b_in;
            r_load_weight <= 1'b1;
            r_busy        <= 1'b1;
            r_x           <= '0;
            r_y           <= '0;
            r_state       <= StLoadW;
          end
        end
        StLoadW: begin
          r_s_ready <= 1'b1;
`ifdef RGB_FEEDER_ZERO_PAD_EN
          r_start_conv <= 1'b1;
          r_state      <= StStream;
`else
          r_state <= StFill;
`endif
        end
        StFill: begin
          if (w_accept && w_x_last && (r_y == YFillLast)) begin
            r_start_conv <= 1'b1;
            r_state      <= StStream;
          end
        end
        StStream: begin
          if (w_accept) begin
            r_col_valid <= 1'b1;
            r_col_last  <= w_x_last & w_y_last;
            for (int c = 0; c < ColRows; c++) begin
              r_col[c] <= w_col[c];
            end
            if (w_x_last && w_y_last) begin
              r_s_ready <= 1'b0;
            end
          end
          // Leave once the last column has been on the outputs for its cycle.
          if (r_col_last) begin
            r_start_conv <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= StDone;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign s_if.s_ready      = r_s_ready;
  assign weights_r         = r_w_r;
  assign weights_g         = r_w_g;
  assign weights_b         = r_w_b;
  assign load_weight       = r_load_weight;
  assign input_col_r       = r_col[0];
  assign input_col_g       = r_col[1];
  assign input_col_b       = r_col[2];
  assign col_valid         = r_col_valid;
  assign col_last          = r_col_last;
  assign start_conv        = r_start_conv;
  assign total_window_done = r_done;
  assign busy              = r_busy;

endmodule

// File: tb/tb_rgb_window_feeder.sv
// Directed bench for rgb_window_feeder on a 4x4 image; pixel = 16*y+x (+1 G, +2 B).
// Honours RGB_FEEDER_ZERO_PAD_EN for the expected column set.
module tb_rgb_window_feeder;

  localparam int unsigned DW = 8;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
`ifdef RGB_FEEDER_ZERO_PAD_EN
  localparam bit Pad = 1'b1;
`else
  localparam bit Pad = 1'b0;
`endif
  localparam int ExpCols = Pad ? W * H : W * (H - 2);

  logic          clk;
  logic          rst;
  logic          start;
  logic [9*DW-1:0] weights_r_in, weights_g_in, weights_b_in;
  logic [9*DW-1:0] weights_r, weights_g, weights_b;
  logic          load_weight;
  logic [3*DW-1:0] input_col_r, input_col_g, input_col_b;
  logic          col_valid, col_last, start_conv, total_window_done, busy;

  int n_checks;
  int n_errors;
  logic [3*DW-1:0] exp_col_r, exp_col_g, exp_col_b;

  rgb_window_feeder_if #(.DATA_WIDTH(DW)) s_if ();

  rgb_window_feeder #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .weights_r_in      (weights_r_in),
    .weights_g_in      (weights_g_in),
    .weights_b_in      (weights_b_in),
    .s_if              (s_if.slave),
    .weights_r         (weights_r),
    .weights_g         (weights_g),
    .weights_b         (weights_b),
    .load_weight       (load_weight),
    .input_col_r       (input_col_r),
    .input_col_g       (input_col_g),
    .input_col_b       (input_col_b),
    .col_valid         (col_valid),
    .col_last          (col_last),
    .start_conv        (start_conv),
    .total_window_done (total_window_done),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int ch, input int x, input int y);
    return DW'(16 * y + x + ch);
  endfunction

  // Column {row y, row y-1, row y-2}; rows above the image are zero.
  function automatic logic [3*DW-1:0] col_model(input int ch, input int x, input int y);
    logic [DW-1:0] top, mid, bot;
    top = pix(ch, x, y);
    mid = (y >= 1) ? pix(ch, x, y - 1) : '0;
    bot = (y >= 2) ? pix(ch, x, y - 2) : '0;
    return {top, mid, bot};
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_s_ready"}, s_if.s_ready, 0);
    check_eq({tag, "_load_weight"}, load_weight, 0);
    check_eq({tag, "_col_valid"}, col_valid, 0);
    check_eq({tag, "_col_last"}, col_last, 0);
    check_eq({tag, "_start_conv"}, start_conv, 0);
    check_eq({tag, "_done"}, total_window_done, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_col_r"}, input_col_r, 0);
    check_eq({tag, "_col_g"}, input_col_g, 0);
    check_eq({tag, "_col_b"}, input_col_b, 0);
    check_eq({tag, "_w_r"}, weights_r, 0);
    check_eq({tag, "_w_g"}, weights_g, 0);
    check_eq({tag, "_w_b"}, weights_b, 0);
  endtask

  // Called just after a rising edge; leaves at t+2 (+1 time unit).
  task automatic do_start(input logic [71:0] wr, input logic [71:0] wg, input logic [71:0] wb);
    start        = 1'b1;
    weights_r_in = wr;
    weights_g_in = wg;
    weights_b_in = wb;
    @(posedge clk);
    #1;
    start        = 1'b0;
    weights_r_in = ~wr;
    weights_g_in = ~wg;
    weights_b_in = ~wb;
    check_eq("start_load_weight", load_weight, 1);
    check_eq("start_busy", busy, 1);
    check_eq("start_s_ready_t1", s_if.s_ready, 0);
    check_eq("start_weights_r", weights_r, wr);
    check_eq("start_weights_g", weights_g, wg);
    check_eq("start_weights_b", weights_b, wb);
    @(posedge clk);
    #1;
    check_eq("start_load_weight_t2", load_weight, 0);
    check_eq("start_s_ready_t2", s_if.s_ready, 1);
    check_eq("start_conv_t2", start_conv, Pad);
  endtask

  // Stream one image, checking every cycle until IDLE; abort_at>0 returns after that column.
  task automatic run_image(input int gap_pct, input bit inject_start, input int abort_at);
    int xi = 0, yi = 0, ncols = 0, cyc = 0, ax = 0, ay = 0;
    bit remaining = 1'b1, exp_sc = Pad, last_prev = 1'b0, done_prev = 1'b0, finished = 1'b0;
    bit acc, exp_cv, exp_lst, exp_done;
    while (!finished && cyc < 400) begin
      cyc++;
      check_eq("s_ready", s_if.s_ready, remaining);
      s_if.s_valid   = remaining && ($urandom_range(0, 99) >= gap_pct);
      s_if.s_pixel_r = pix(0, xi, yi);
      s_if.s_pixel_g = pix(1, xi, yi);
      s_if.s_pixel_b = pix(2, xi, yi);
      if (inject_start && ncols == 2) begin
        start        = 1'b1;
        weights_r_in = 72'hdeadbeef_cafef00d_55;
      end
      acc = s_if.s_valid;
      @(posedge clk);
      #1;
      start    = 1'b0;
      exp_done = last_prev;
      exp_cv   = 1'b0;
      exp_lst  = 1'b0;
      if (acc) begin
        ax = xi;
        ay = yi;
        if (xi == W - 1) begin
          xi = 0;
          yi++;
        end else begin
          xi++;
        end
        if (ax == W - 1 && ay == H - 1) remaining = 1'b0;
        if (!Pad && ax == W - 1 && ay == 1) exp_sc = 1'b1;
        if (Pad || ay >= 2) begin
          exp_cv    = 1'b1;
          exp_lst   = (ax == W - 1 && ay == H - 1);
          exp_col_r = col_model(0, ax, ay);
          exp_col_g = col_model(1, ax, ay);
          exp_col_b = col_model(2, ax, ay);
          ncols++;
        end
      end
      if (exp_done) exp_sc = 1'b0;
      if (done_prev) begin
        check_eq("idle_busy", busy, 0);
        check_eq("idle_start_conv", start_conv, 0);
        check_eq("column_count", ncols, ExpCols);
        finished = 1'b1;
      end else begin
        check_eq("col_valid", col_valid, exp_cv);
        check_eq("col_last", col_last, exp_lst);
        check_eq("col_r", input_col_r, exp_col_r);
        check_eq("col_g", input_col_g, exp_col_g);
        check_eq("col_b", input_col_b, exp_col_b);
        check_eq("start_conv", start_conv, exp_sc);
        check_eq("window_done", total_window_done, exp_done);
        check_eq("busy", busy, 1);
      end
      last_prev = exp_lst;
      done_prev = exp_done;
      if (abort_at > 0 && ncols == abort_at) begin
        s_if.s_valid = 1'b0;
        return;
      end
    end
    s_if.s_valid = 1'b0;
    check_eq("image_completed", finished, 1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    exp_col_r = '0;
    exp_col_g = '0;
    exp_col_b = '0;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  localparam logic [71:0] W1R = 72'h090807060504030201;
  localparam logic [71:0] W1G = 72'h191817161514131211;
  localparam logic [71:0] W1B = 72'h292827262524232221;
  localparam logic [71:0] W2R = 72'h0102030405060708ff;
  localparam logic [71:0] W3R = 72'ha5a5a5a5a5a5a5a501;

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    clk          = 1'b0;
    start        = 1'b0;
    weights_r_in = '0;
    weights_g_in = '0;
    weights_b_in = '0;
    s_if.s_valid   = 1'b0;
    s_if.s_pixel_r = '0;
    s_if.s_pixel_g = '0;
    s_if.s_pixel_b = '0;

    apply_reset();
    check_all_zero("post_reset_idle");

    // Back-to-back pixels.
    do_start(W1R, W1G, W1B);
    run_image(0, 1'b0, 0);

    // ~30% idle cycles on the stream.
    do_start(W2R, W1G, W1B);
    run_image(30, 1'b0, 0);
    check_eq("gap_weights_r", weights_r, W2R);

    // start during STREAM must be ignored.
    do_start(W3R, W1G, W1B);
    run_image(0, 1'b1, 0);
    check_eq("ignored_start_weights_r", weights_r, W3R);
    check_eq("ignored_start_busy", busy, 0);

    // Reset in the middle of an image, then a clean image over stale RAM.
    do_start(W1R, W1G, W1B);
    run_image(0, 1'b0, 3);
    check_eq("pre_abort_busy", busy, 1);
    apply_reset();
    do_start(W1R, W1G, W1B);
    run_image(20, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
